// File: rtl/systolic_sample_feeder_if.sv
// Sample-feeder bus: FIFO writer, run control and the stream toward systolicFilter.
// The master modport is the controlling side (writer / sequencer); the slave modport is the feeder.
interface systolic_sample_feeder_if #(
  parameter int unsigned DATA_W  = 18,
  parameter int unsigned RATE_W  = 8,
  parameter int unsigned LEVEL_W = 5
);
  logic [DATA_W-1:0]  wr_data;
  logic               wr_en;
  logic               start;
  logic               stop;
  logic               mode;
  logic [RATE_W-1:0]  rate;
  logic [DATA_W-1:0]  impulse_val;
  logic [DATA_W-1:0]  data;
  logic               data_nd;
  logic               busy;
  logic               full;
  logic [LEVEL_W-1:0] level;
  logic               overflow;
  logic               underrun;

  modport master (
    output wr_data, wr_en, start, stop, mode, rate, impulse_val,
    input  data, data_nd, busy, full, level, overflow, underrun
  );

  modport slave (
    input  wr_data, wr_en, start, stop, mode, rate, impulse_val,
    output data, data_nd, busy, full, level, overflow, underrun
  );
endinterface

// File: rtl/systolic_sample_feeder.sv
// Feeds systolicFilter: buffers samples in a FIFO and emits them at a programmable strobe
// rate, or emits a FRAME_LEN-sample impulse frame (one ImpulseVal followed by zeros).
module systolic_sample_feeder #(
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned RATE_W     = 8,
  parameter int unsigned FRAME_LEN  = 256
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  systolic_sample_feeder_if.slave bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned IdxW = $clog2(FRAME_LEN);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(FIFO_DEPTH);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(FRAME_LEN - 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e             r_state, w_state_d;
  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [LvlW-1:0]    r_level, w_level_d;
  logic               r_full, r_overflow, r_underrun;
  logic [DATA_W-1:0]  r_data, w_data_d;
  logic               r_data_nd, w_data_nd_d;
  logic               r_mode;
  logic [RATE_W-1:0]  r_rate;
  logic [DATA_W-1:0]  r_imp_val;
  logic [RATE_W-1:0]  r_cnt, w_cnt_d;
  logic [IdxW-1:0]    r_idx, w_idx_d;
  logic               w_push, w_pop, w_latch, w_underrun_set, w_tick;

  // Full blocks the write even when a pop happens on the same edge.
  assign w_push = bus.wr_en & ~r_full;
  assign w_tick = (r_cnt == r_rate);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_idx_d        = r_idx;
    w_data_d       = r_data;
    w_data_nd_d    = 1'b0;
    w_pop          = 1'b0;
    w_latch        = 1'b0;
    w_underrun_set = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_d = StRun;
          w_latch   = 1'b1;
          w_cnt_d   = '0;
          w_idx_d   = '0;
        end
      end
      StRun: begin
        if (bus.stop) begin
          w_state_d = StIdle;
        end else if (w_tick) begin
          w_cnt_d     = '0;
          w_data_nd_d = 1'b1;
          if (!r_mode) begin
            // An empty tick still strobes a zero so the filter keeps its cadence.
            if (r_level != '0) begin
              w_pop    = 1'b1;
              w_data_d = r_mem[r_rd_ptr];
            end else begin
              w_data_d       = '0;
              w_underrun_set = 1'b1;
            end
          end else begin
            w_data_d = (r_idx == '0) ? r_imp_val : '0;
            w_idx_d  = r_idx + IdxW'(1);
            if (r_idx == IdxLast) begin
              w_state_d = StIdle;
            end
          end
        end else begin
          w_cnt_d = r_cnt + RATE_W'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_level_d = r_level;
    if (w_push && !w_pop) begin
      w_level_d = r_level + LvlW'(1);
    end else if (!w_push && w_pop) begin
      w_level_d = r_level - LvlW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
      r_data     <= '0;
      r_data_nd  <= 1'b0;
      r_mode     <= 1'b0;
      r_rate     <= '0;
      r_imp_val  <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_level    <= w_level_d;
      r_full     <= (w_level_d == LvlFull);
      r_overflow <= r_overflow | (bus.wr_en & r_full);
      r_underrun <= r_underrun | w_underrun_set;
      r_data     <= w_data_d;
      r_data_nd  <= w_data_nd_d;
      r_cnt      <= w_cnt_d;
      r_idx      <= w_idx_d;
      if (w_latch) begin
        r_mode    <= bus.mode;
        r_rate    <= bus.rate;
        r_imp_val <= bus.impulse_val;
      end
    end
  end

  assign bus.data     = r_data;
  assign bus.data_nd  = r_data_nd;
  assign bus.busy     = (r_state == StRun);
  assign bus.full     = r_full;
  assign bus.level    = r_level;
  assign bus.overflow = r_overflow;
  assign bus.underrun = r_underrun;

endmodule
